// File: rtl/pcie_vc_router.sv
// pcie_vc_router
// Multi-port, multi-VC transaction buffer. Each input port steers words into
// one FIFO per virtual channel. A round-robin arbiter drains those FIFOs into
// a registered output stage that uses a ready/valid handshake. Each FIFO has
// its own pause/continue flow control with hysteresis, and a small state
// machine reports init/idle/active/error.
//
// Ports:
//   clock, reset       rising-edge clock, asynchronous active-low reset
//   init               threshold load / global flush request
//   umbral_high/low    pause / continue occupancy thresholds (latched in INIT)
//   valid_in, data_in  per-port write strobe and {vc, payload} word
//   out_ready          per-port downstream ready
//   valid_out, data_out, vc_out  per-port registered output word
//   pause, continue_vc per-FIFO flow-control level / one-cycle pulse (p*NUM_VC+v)
//   idle, active, error          one-hot state indicators (none while in INIT)
//   umbrales_VCFC      latched {high, low}
module pcie_vc_router #(
  parameter int DATA_WIDTH = 5,
  parameter int VC_BITS    = 1,
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     init,
  input  logic [ADDR_WIDTH:0]                      umbral_high,
  input  logic [ADDR_WIDTH:0]                      umbral_low,
  input  logic [NUM_PORTS-1:0]                     valid_in,
  input  logic [NUM_PORTS*(DATA_WIDTH+VC_BITS)-1:0] data_in,
  input  logic [NUM_PORTS-1:0]                     out_ready,
  output logic [NUM_PORTS-1:0]                     valid_out,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]          data_out,
  output logic [NUM_PORTS*VC_BITS-1:0]             vc_out,
  output logic [NUM_PORTS*(1<<VC_BITS)-1:0]        pause,
  output logic [NUM_PORTS*(1<<VC_BITS)-1:0]        continue_vc,
  output logic                                     idle,
  output logic                                     active,
  output logic                                     error,
  output logic [2*(ADDR_WIDTH+1)-1:0]              umbrales_VCFC
);

  localparam int NUM_VC   = 1 << VC_BITS;
  localparam int DEPTH    = 1 << ADDR_WIDTH;
  localparam int NUM_FIFO = NUM_PORTS * NUM_VC;
  localparam int CW       = ADDR_WIDTH + 1;
  localparam int WW       = DATA_WIDTH + VC_BITS;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_ACTIVE, ST_ERROR} state_t;

  // FIFO storage and bookkeeping, indexed p*NUM_VC+v
  logic [DATA_WIDTH-1:0] mem_q      [NUM_FIFO][DEPTH];
  logic [CW-1:0]         count_q    [NUM_FIFO];
  logic [CW-1:0]         count_d    [NUM_FIFO];
  logic [ADDR_WIDTH-1:0] wr_ptr_q   [NUM_FIFO];
  logic [ADDR_WIDTH-1:0] wr_ptr_d   [NUM_FIFO];
  logic [ADDR_WIDTH-1:0] rd_ptr_q   [NUM_FIFO];
  logic [ADDR_WIDTH-1:0] rd_ptr_d   [NUM_FIFO];
  logic [NUM_FIFO-1:0]   pause_q, pause_d;
  logic [NUM_FIFO-1:0]   cont_q, cont_d;

  // Output stage and arbiter state per port
  logic [NUM_PORTS-1:0]  valid_out_q, valid_out_d;
  logic [DATA_WIDTH-1:0] data_out_q [NUM_PORTS];
  logic [DATA_WIDTH-1:0] data_out_d [NUM_PORTS];
  logic [VC_BITS-1:0]    vc_out_q   [NUM_PORTS];
  logic [VC_BITS-1:0]    vc_out_d   [NUM_PORTS];
  logic [VC_BITS-1:0]    rr_ptr_q   [NUM_PORTS];
  logic [VC_BITS-1:0]    rr_ptr_d   [NUM_PORTS];

  // Thresholds and state machine
  logic [CW-1:0] high_q, high_d, low_q, low_d;
  state_t        state_q, state_d;
  logic          idle_q, active_q, error_q;

  // Decoded input words
  logic [VC_BITS-1:0]    in_vc      [NUM_PORTS];
  logic [DATA_WIDTH-1:0] in_payload [NUM_PORTS];
  logic [NUM_FIFO-1:0]   push, pop, overflow_vec;
  logic [DATA_WIDTH-1:0] push_data  [NUM_FIFO];
  logic                  found;
  logic [VC_BITS-1:0]    grant, cand;
  logic                  all_empty;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      in_payload[p] = data_in[p*WW +: DATA_WIDTH];
      in_vc[p]      = data_in[p*WW + DATA_WIDTH +: VC_BITS];
    end
  end

  // Push decode. A full FIFO (judged on the pre-edge count) rejects the word
  // even if it pops on the same edge; the rejected word raises overflow.
  always_comb begin
    push         = '0;
    overflow_vec = '0;
    for (int f = 0; f < NUM_FIFO; f++) push_data[f] = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int v = 0; v < NUM_VC; v++) begin
        if (valid_in[p] && !init && in_vc[p] == VC_BITS'(v)) begin
          if (count_q[p*NUM_VC+v] == CW'(DEPTH)) begin
            overflow_vec[p*NUM_VC+v] = 1'b1;
          end else begin
            push[p*NUM_VC+v]      = 1'b1;
            push_data[p*NUM_VC+v] = in_payload[p];
          end
        end
      end
    end
  end

  // Output stage with round-robin arbitration. The search starts one past the
  // last granted VC; the pointer only moves when a word is actually popped.
  always_comb begin
    pop   = '0;
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      valid_out_d[p] = valid_out_q[p];
      data_out_d[p]  = data_out_q[p];
      vc_out_d[p]    = vc_out_q[p];
      rr_ptr_d[p]    = rr_ptr_q[p];
      if (init) begin
        valid_out_d[p] = 1'b0;
        data_out_d[p]  = '0;
        vc_out_d[p]    = '0;
        rr_ptr_d[p]    = '0;
      end else if (!valid_out_q[p] || out_ready[p]) begin
        found = 1'b0;
        grant = '0;
        for (int i = 1; i <= NUM_VC; i++) begin
          cand = rr_ptr_q[p] + VC_BITS'(i);
          if (!found && count_q[p*NUM_VC + int'(cand)] != '0) begin
            found = 1'b1;
            grant = cand;
          end
        end
        valid_out_d[p] = found;
        if (found) begin
          for (int v = 0; v < NUM_VC; v++) begin
            if (grant == VC_BITS'(v)) begin
              data_out_d[p]    = mem_q[p*NUM_VC+v][rd_ptr_q[p*NUM_VC+v]];
              pop[p*NUM_VC+v]  = 1'b1;
            end
          end
          vc_out_d[p] = grant;
          rr_ptr_d[p] = grant;
        end
      end
    end
  end

  // FIFO counters and flow control. Pause/continue look at the post-edge
  // count so they change on the same edge as the push/pop that moved it.
  always_comb begin
    for (int f = 0; f < NUM_FIFO; f++) begin
      count_d[f]  = count_q[f] + CW'(push[f]) - CW'(pop[f]);
      wr_ptr_d[f] = wr_ptr_q[f] + ADDR_WIDTH'(push[f]);
      rd_ptr_d[f] = rd_ptr_q[f] + ADDR_WIDTH'(pop[f]);
      pause_d[f]  = pause_q[f];
      cont_d[f]   = 1'b0;
      if (!pause_q[f]) begin
        pause_d[f] = (count_d[f] >= high_q);
      end else if (count_d[f] <= low_q) begin
        pause_d[f] = 1'b0;
        cont_d[f]  = 1'b1;
      end
      if (init) begin
        count_d[f]  = '0;
        wr_ptr_d[f] = '0;
        rd_ptr_d[f] = '0;
        pause_d[f]  = 1'b0;
        cont_d[f]   = 1'b0;
      end
    end
  end

  // Thresholds are sampled only while sitting in INIT with init held high
  always_comb begin
    high_d = high_q;
    low_d  = low_q;
    if (state_q == ST_INIT && init) begin
      high_d = umbral_high;
      low_d  = umbral_low;
    end
  end

  always_comb begin
    all_empty = 1'b1;
    for (int f = 0; f < NUM_FIFO; f++) begin
      if (count_q[f] != '0) all_empty = 1'b0;
    end
  end

  // Next state. init overrides everything; ERROR is left only through init.
  always_comb begin
    state_d = state_q;
    if (init) begin
      state_d = ST_INIT;
    end else begin
      case (state_q)
        ST_INIT:   state_d = ST_IDLE;
        ST_IDLE: begin
          if (|overflow_vec)  state_d = ST_ERROR;
          else if (|valid_in) state_d = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (|overflow_vec) state_d = ST_ERROR;
          else if (all_empty && !(|valid_out_q) && !(|valid_in)) state_d = ST_IDLE;
        end
        default:   state_d = ST_ERROR;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_INIT;
      idle_q   <= 1'b0;
      active_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idle_q   <= (state_d == ST_IDLE);
      active_q <= (state_d == ST_ACTIVE);
      error_q  <= (state_d == ST_ERROR);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int f = 0; f < NUM_FIFO; f++) begin
        count_q[f]  <= '0;
        wr_ptr_q[f] <= '0;
        rd_ptr_q[f] <= '0;
      end
      pause_q     <= '0;
      cont_q      <= '0;
      valid_out_q <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        data_out_q[p] <= '0;
        vc_out_q[p]   <= '0;
        rr_ptr_q[p]   <= '0;
      end
      high_q <= CW'(DEPTH);
      low_q  <= CW'(DEPTH / 2);
    end else begin
      for (int f = 0; f < NUM_FIFO; f++) begin
        count_q[f]  <= count_d[f];
        wr_ptr_q[f] <= wr_ptr_d[f];
        rd_ptr_q[f] <= rd_ptr_d[f];
      end
      pause_q     <= pause_d;
      cont_q      <= cont_d;
      valid_out_q <= valid_out_d;
      for (int p = 0; p < NUM_PORTS; p++) begin
        data_out_q[p] <= data_out_d[p];
        vc_out_q[p]   <= vc_out_d[p];
        rr_ptr_q[p]   <= rr_ptr_d[p];
      end
      high_q <= high_d;
      low_q  <= low_d;
    end
  end

  // Payload storage carries no reset; occupancy is tracked by the counters
  always_ff @(posedge clock) begin
    for (int f = 0; f < NUM_FIFO; f++) begin
      if (push[f]) mem_q[f][wr_ptr_q[f]] <= push_data[f];
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      data_out[p*DATA_WIDTH +: DATA_WIDTH] = data_out_q[p];
      vc_out[p*VC_BITS +: VC_BITS]         = vc_out_q[p];
    end
  end

  assign valid_out     = valid_out_q;
  assign pause         = pause_q;
  assign continue_vc   = cont_q;
  assign idle          = idle_q;
  assign active        = active_q;
  assign error         = error_q;
  assign umbrales_VCFC = {high_q, low_q};

endmodule
